// File: rtl/xfer_pkg.sv
// Shared types and sizing helpers for the memory block-transfer initiator.
package xfer_pkg;

    // Default number of 16-bit words in one cache block.
    localparam int XFER_BLOCK_WORDS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } xfer_state_e;

    // Width of a word index within a block.
    function automatic int idx_w(input int block_words);
        return $clog2(block_words);
    endfunction

    // Width of the byte offset within a block (word index plus byte-in-word bit).
    function automatic int off_w(input int block_words);
        return $clog2(block_words) + 1;
    endfunction

endpackage

// File: rtl/xfer_word_ctr.sv
// Word counter for block transfers: clear, increment, and a last-word flag.
module xfer_word_ctr
    import xfer_pkg::*;
#(
    parameter  int BLOCK_WORDS = XFER_BLOCK_WORDS,
    localparam int IDX_W       = idx_w(BLOCK_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] cnt,
    output logic             last
);

    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        // NOTE: assigning the hold value first means every path drives cnt_d, so no latch is inferred.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + IDX_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of block order.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    // BLOCK_WORDS is a power of two, so the last word is the all-ones index.
    assign last = &cnt_q;

endmodule

// File: rtl/mem_block_xfer.sv
// Block-transfer initiator: optional dirty-victim writeback, then block fill,
// one 16-bit word per cycle on the memory port.
// Build option: define XFER_WRITEBACK_EN to include the writeback phase.
module mem_block_xfer
    import xfer_pkg::*;
#(
    parameter  int ADDR_WIDTH  = 16,
    parameter  int BLOCK_WORDS = XFER_BLOCK_WORDS,
    localparam int IDX_W       = idx_w(BLOCK_WORDS),
    localparam int OFF_W       = off_w(BLOCK_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fill_req,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [15:0]           wb_data,
    output logic [IDX_W-1:0]      wb_word_idx,
    output logic [15:0]           fill_data,
    output logic [IDX_W-1:0]      fill_word_idx,
    output logic                  fill_we,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata
);

    localparam int TAG_W = ADDR_WIDTH - OFF_W;

    xfer_state_e      state_q, state_d;
    logic [TAG_W-1:0] fill_tag_q, fill_tag_d;
    logic             ctr_clr, ctr_inc, cnt_last;
    logic [IDX_W-1:0] cnt;

`ifdef XFER_WRITEBACK_EN
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
    logic             unused_inputs;
    assign unused_inputs = ^{fill_addr[OFF_W-1:0], wb_addr[OFF_W-1:0]};
`else
    logic             unused_inputs;
    assign unused_inputs = ^{fill_addr[OFF_W-1:0], wb_valid, wb_addr, wb_data};
`endif

    xfer_word_ctr #(.BLOCK_WORDS(BLOCK_WORDS)) u_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (ctr_clr),
        .inc  (ctr_inc),
        .cnt  (cnt),
        .last (cnt_last)
    );

    // Next-state logic and block-base capture; request inputs matter only in IDLE.
    always_comb begin
        state_d    = state_q;
        fill_tag_d = fill_tag_q;
`ifdef XFER_WRITEBACK_EN
        wb_tag_d   = wb_tag_q;
`endif
        ctr_clr    = 1'b0;
        ctr_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fill_req) begin
                    fill_tag_d = fill_addr[ADDR_WIDTH-1:OFF_W];
                    ctr_clr    = 1'b1;
`ifdef XFER_WRITEBACK_EN
                    wb_tag_d   = wb_addr[ADDR_WIDTH-1:OFF_W];
                    state_d    = wb_valid ? WB : FILL;
`else
                    state_d    = FILL;
`endif
                end
            end
            WB: begin
`ifdef XFER_WRITEBACK_EN
                ctr_inc = 1'b1;
                if (cnt_last) begin
                    ctr_clr = 1'b1;
                    state_d = FILL;
                end
`else
                state_d = IDLE;
`endif
            end
            FILL: begin
                ctr_inc = 1'b1;
                if (cnt_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any transfer in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Block base tags; only meaningful after being captured on acceptance.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; the tags are always written before any state reads them.
        fill_tag_q <= fill_tag_d;
`ifdef XFER_WRITEBACK_EN
        wb_tag_q   <= wb_tag_d;
`endif
    end

    // Output decode from registered state and counter; word offset fills the cleared low bits.
    always_comb begin
        busy          = (state_q != IDLE);
        done          = 1'b0;
        mem_enable    = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        wb_word_idx   = '0;
        fill_we       = 1'b0;
        fill_word_idx = '0;
        fill_data     = '0;
        case (state_q)
            WB: begin
`ifdef XFER_WRITEBACK_EN
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = {wb_tag_q, cnt, 1'b0};
                wb_word_idx = cnt;
                mem_wdata   = wb_data;
`endif
            end
            FILL: begin
                mem_enable    = 1'b1;
                mem_addr      = {fill_tag_q, cnt, 1'b0};
                fill_we       = 1'b1;
                fill_word_idx = cnt;
                fill_data     = mem_rdata;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_block_xfer.sv
// Self-checking bench for mem_block_xfer with a transaction-level reference model.
module tb_mem_block_xfer;

    localparam int BW = 8;

`ifdef XFER_WRITEBACK_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fill_req = 1'b0;
    logic [15:0] fill_addr = '0;
    logic        wb_valid = 1'b0;
    logic [15:0] wb_addr = '0;
    logic [15:0] wb_data;
    logic [2:0]  wb_word_idx;
    logic [15:0] fill_data;
    logic [2:0]  fill_word_idx;
    logic        fill_we, busy, done;
    logic [15:0] mem_addr;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_wdata, mem_rdata;

    logic [15:0] mem      [0:32767];
    logic [15:0] ref_mem  [0:32767];
    logic [15:0] cache_wb   [0:BW-1];
    logic [15:0] cache_fill [0:BW-1];
    logic [15:0] exp_fill   [0:BW-1];

    int passed = 0;
    int total  = 0;

    logic [63:0] obs_vec;

    mem_block_xfer #(.ADDR_WIDTH(16), .BLOCK_WORDS(BW)) dut (
        .clk           (clk),
        .rst           (rst),
        .fill_req      (fill_req),
        .fill_addr     (fill_addr),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .wb_word_idx   (wb_word_idx),
        .fill_data     (fill_data),
        .fill_word_idx (fill_word_idx),
        .fill_we       (fill_we),
        .busy          (busy),
        .done          (done),
        .mem_addr      (mem_addr),
        .mem_enable    (mem_enable),
        .mem_wr        (mem_wr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: combinational read, write on rising edge. Cache: combinational victim read, fill on edge.
    assign mem_rdata = mem[mem_addr[15:1]];
    assign wb_data   = cache_wb[wb_word_idx];

    always @(posedge clk) begin
        if (mem_enable && mem_wr) mem[mem_addr[15:1]] <= mem_wdata;
        if (fill_we) cache_fill[fill_word_idx] <= fill_data;
    end

    assign obs_vec = {5'b0, busy, done, mem_enable, mem_wr, mem_addr, mem_wdata,
                      fill_we, fill_word_idx, fill_data, wb_word_idx};

    function automatic logic [63:0] ev(bit b, bit dn, bit en, bit wr, logic [15:0] a,
                                       logic [15:0] wd, bit fwe, logic [2:0] fi,
                                       logic [15:0] fd, logic [2:0] wi);
        return {5'b0, b, dn, en, wr, a, wd, fwe, fi, fd, wi};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One complete transfer: expected per-cycle trace built from the transfer rules,
    // request inputs scrambled after acceptance to show they are ignored.
    task automatic run_xfer(input logic [15:0] fa, input bit wv, input logic [15:0] wa,
                            input bit hold, input string name);
        logic [63:0] trace[$];
        logic [15:0] fb, wbb, a;
        bit          do_wb;
        @(negedge clk);
        check({name, "_idle"}, obs_vec, 64'h0);
        fill_req  = 1'b1;
        fill_addr = fa;
        wb_valid  = wv;
        wb_addr   = wa;
        fb    = fa & 16'hFFF0;
        wbb   = wa & 16'hFFF0;
        do_wb = wv && WB_EN;
        if (do_wb) begin
            for (int k = 0; k < BW; k++) begin
                a = wbb + 16'(2 * k);
                trace.push_back(ev(1, 0, 1, 1, a, cache_wb[k], 0, 3'd0, 16'h0, 3'(k)));
                ref_mem[a[15:1]] = cache_wb[k];
            end
        end
        for (int k = 0; k < BW; k++) begin
            a = fb + 16'(2 * k);
            exp_fill[k] = ref_mem[a[15:1]];
            trace.push_back(ev(1, 0, 1, 0, a, 16'h0, 1, 3'(k), exp_fill[k], 3'd0));
        end
        trace.push_back(ev(1, 1, 0, 0, 16'h0, 16'h0, 0, 3'd0, 16'h0, 3'd0));
        for (int i = 0; i < trace.size(); i++) begin
            @(negedge clk);
            check($sformatf("%s_c%0d", name, i + 1), obs_vec, trace[i]);
            fill_addr = 16'($urandom);
            wb_addr   = 16'($urandom);
            wb_valid  = 1'($urandom);
            if (i == trace.size() - 1) fill_req = hold;
        end
        for (int k = 0; k < BW; k++) begin
            check($sformatf("%s_cache%0d", name, k), {48'h0, cache_fill[k]}, {48'h0, exp_fill[k]});
        end
        if (do_wb) begin
            for (int k = 0; k < BW; k++) begin
                a = wbb + 16'(2 * k);
                check($sformatf("%s_mem%0d", name, k), {48'h0, mem[a[15:1]]}, {48'h0, ref_mem[a[15:1]]});
            end
        end
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] a;
        for (int i = 0; i < 32768; i++) begin
            v = 16'($urandom);
            mem[i]     = v;
            ref_mem[i] = v;
        end
        for (int k = 0; k < BW; k++) begin
            a = 16'h1230 + 16'(2 * k);
            mem[a[15:1]]     = 16'hA000 + 16'(k);
            ref_mem[a[15:1]] = 16'hA000 + 16'(k);
            cache_wb[k]      = 16'hB000 + 16'(k);
            cache_fill[k]    = 16'h0;
        end

        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", obs_vec, 64'h0);
        rst = 1'b0;

        // Directed transfers.
        run_xfer(16'h1236, 1'b0, 16'h0000, 1'b0, "fill_only");
        run_xfer(16'h0010, 1'b1, 16'h4008, 1'b0, "wb_fill");
        run_xfer(16'hFFFE, 1'b0, 16'h0000, 1'b0, "wrap");
        run_xfer(16'h2000, 1'b0, 16'h0000, 1'b1, "held_a");
        run_xfer(16'h3002, 1'b0, 16'h0000, 1'b0, "held_b");

        // Reset during the fourth fill word.
        @(negedge clk);
        check("rstmid_idle", obs_vec, 64'h0);
        fill_req  = 1'b1;
        fill_addr = 16'h7000;
        wb_valid  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a = 16'h7000 + 16'(2 * k);
            check($sformatf("rstmid_w%0d", k), obs_vec,
                  ev(1, 0, 1, 0, a, 16'h0, 1, 3'(k), ref_mem[a[15:1]], 3'd0));
        end
        rst      = 1'b1;
        fill_req = 1'b0;
        @(negedge clk);
        check("rst_abort", obs_vec, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_nodone", obs_vec, 64'h0);
        run_xfer(16'h7004, 1'b0, 16'h0000, 1'b0, "post_rst");

        // Dirty victim: writeback only when compiled in.
        run_xfer(16'h5000, 1'b1, 16'h6000, 1'b0, "wb_valid_case");

        // Randomized transfers.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < BW; k++) cache_wb[k] = 16'($urandom);
            run_xfer(16'($urandom), 1'($urandom), 16'($urandom), 1'b0, $sformatf("rand%0d", r));
        end

        @(negedge clk);
        check("final_idle", obs_vec, 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_block_xfer.md
# mem_block_xfer

Block-transfer initiator that drives the word-wide, byte-addressed memory port (combinational read, write on rising edge) on behalf of the cache. On a miss it optionally writes back a dirty victim block word-by-word, then reads the missing block word-by-word and streams each word into the cache data array. It sits between the cache controller and main memory and is the only master of the memory port.

## Interface
- ADDR_WIDTH, 16, byte-address width of memory and cache addresses
- BLOCK_WORDS, 8, 16-bit words per cache block; power of two, at least 2
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- fill_req  in  1  level request for a block transfer; sampled only in IDLE
- fill_addr  in  ADDR_WIDTH  miss byte address; low OFF_W = log2(BLOCK_WORDS)+1 bits ignored
- wb_valid  in  1  victim block is dirty; sampled with fill_req
- wb_addr  in  ADDR_WIDTH  victim byte address; low OFF_W bits ignored
- wb_data  in  16  victim word selected by wb_word_idx; combinational from cache
- wb_word_idx  out  log2(BLOCK_WORDS)  victim word index being written back
- fill_data  out  16  word read from memory, passes straight through from mem_rdata
- fill_word_idx  out  log2(BLOCK_WORDS)  cache word index for fill_data
- fill_we  out  1  cache writes fill_data at fill_word_idx this cycle
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse: transfer complete
- mem_addr  out  ADDR_WIDTH  memory byte address, bit 0 always 0
- mem_enable  out  1  memory access this cycle
- mem_wr  out  1  1 = write, 0 = read
- mem_wdata  out  16  write data to memory (= wb_data during WB)
- mem_rdata  in  16  read data from memory, valid same cycle

## Operation
- States: IDLE, WB, FILL, DONE; word counter cnt, width log2(BLOCK_WORDS).
- IDLE: all memory/cache strobes 0. If fill_req=1 at an edge: latch fill_base and wb_base (addresses with low OFF_W bits cleared), cnt<=0; next state WB if wb_valid=1 and writeback is compiled in, else FILL.
- WB: mem_enable=1, mem_wr=1, mem_addr=wb_base+2*cnt, wb_word_idx=cnt, mem_wdata=wb_data. cnt increments each cycle; when cnt=BLOCK_WORDS-1, go to FILL with cnt<=0.
- FILL: mem_enable=1, mem_wr=0, mem_addr=fill_base+2*cnt, fill_we=1, fill_word_idx=cnt, fill_data=mem_rdata. When cnt=BLOCK_WORDS-1, go to DONE.
- DONE: done=1, no memory access; go to IDLE.
- Address arithmetic: offset 2*cnt is concatenated into the cleared low bits. No carry into the tag/index bits occurs, including at the last word.
- fill_req, fill_addr, wb_valid, and wb_addr are ignored outside IDLE. Changing them mid-transfer has no effect.
- The requester deasserts fill_req in the cycle done=1. If fill_req is still high in IDLE, a new transfer starts.
- Outside the WB and FILL states respectively: fill_data=0, mem_wdata=0, and both index outputs are 0.

## Timing
- All control outputs decode from registered state and cnt. The only combinational paths are mem_rdata→fill_data and wb_data→mem_wdata.
- Reset: state IDLE, cnt 0. All outputs are 0 from the first edge with rst=1.
- Fill-only latency: request accepted at edge T. FILL occupies cycles T+1..T+BLOCK_WORDS, and done is high in cycle T+BLOCK_WORDS+1.
- Latency with writeback: WB occupies T+1..T+BLOCK_WORDS, FILL occupies T+BLOCK_WORDS+1..T+2*BLOCK_WORDS, and done is high in cycle T+2*BLOCK_WORDS+1.
- Read and write never share a cycle. The WB→FILL transition has no idle bubble.
- Reset mid-transfer: abort at that edge and return to IDLE. No done pulse. The remaining words are neither written nor filled.

## Configuration
- XFER_WRITEBACK_EN defined: WB state exists, and wb_valid triggers the writeback phase.
- XFER_WRITEBACK_EN not defined: WB state is compiled out and wb_valid/wb_addr/wb_data are ignored. wb_word_idx is tied to 0, mem_wr is tied to 0, and every transfer is a fill only.

## Structure
- Package xfer_pkg holds the state enum (IDLE, WB, FILL, DONE), the default BLOCK_WORDS, and functions for OFF_W and the index width.
- Sub-module xfer_word_ctr contains the cnt register with clear, increment, and last-word flag.

## Test plan
- Fill-only: memory word at 0x1230+2k = 0xA000+k, fill_req with fill_addr=0x1236, wb_valid=0 -> mem_addr steps 0x1230..0x123E, fill_we high for cycles T+1..T+8 with data 0xA000..0xA007, done at T+9.
- Writeback+fill: wb_valid=1, wb_addr=0x4008, cache words 0xB000+k, fill_addr=0x0010 -> writes 0x4000..0x400E, then reads 0x0010..0x001E, done at T+17, memory at 0x4000+2k = 0xB000+k.
- Block wrap: fill_addr=0xFFFE -> addresses 0xFFF0..0xFFFE, no wrap to 0x0000.
- Held request: fill_req held high across done -> second transfer starts the cycle after DONE, busy low for exactly one cycle.
- Reset mid-fill: rst asserted at word 3 -> all strobes 0 next cycle, no done, fresh request behaves as a normal fill.
- Macro off: wb_valid=1 -> no mem_wr cycle ever, done at T+9.
